// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared defaults, field widths and next-PC source codes
package npc_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] TRAP_PC_DEF  = 32'h0000_4180;
  localparam int          INDEX_W      = 26;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_J,
    SRC_JR,
    SRC_RAS,
    SRC_EXC,
    SRC_HOLD
  } npc_src_e;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack; a push while full overwrites the oldest entry
module ras_stack #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     top_idx;
  logic [CW-1:0]     count;
  logic              do_pop;

  // ptr names the next free slot; once full it also names the oldest entry
  assign top_idx = ptr - PW'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == CW'(RAS_DEPTH));
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && !do_pop) begin
      ptr <= ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (do_pop && !push) begin
      ptr   <= top_idx;
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      if (do_pop) mem[top_idx] <= push_data;
      else        mem[ptr]     <= push_data;
    end
  end

endmodule

// File: rtl/npc_ras_unit.sv
// rtl/npc_ras_unit.sv - next-PC arbitration, PC register and RAS-predicted returns
// Optional NPC_ALIGN_TRAP_EN: misaligned targets go to TRAP_PC and pulse misalign_trap.
module npc_ras_unit
  import npc_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter logic [ADDR_W-1:0] TRAP_PC  = ADDR_W'(TRAP_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               ex_redirect,
  input  logic [ADDR_W-1:0]  ex_redirect_pc,
  input  logic [ADDR_W-1:0]  id_pc_plus4,
  input  logic               id_jr,
  input  logic               id_jr_ra,
  input  logic [ADDR_W-1:0]  id_jr_target,
  input  logic               id_jump,
  input  logic [INDEX_W-1:0] id_instr_index,
  input  logic               id_branch_taken,
  input  logic [ADDR_W-1:0]  id_ext_imm,
  input  logic               id_push,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  pc_plus4_out,
  output logic               ras_hit,
  output logic               ras_empty,
`ifdef NPC_ALIGN_TRAP_EN
  output logic               misalign_trap,
`endif
  output logic               ras_full
);

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0 || TRAP_PC[1:0] != 2'b00) begin : g_bad_cfg
    $error("npc_ras_unit: RAS_DEPTH must be a power of 2 >= 2 and TRAP_PC word aligned");
  end

  npc_src_e          next_src;
  logic [ADDR_W-1:0] raw_pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_push;

  assign pc_plus4_out = pc_out + ADDR_W'(4);

  always_comb begin
    next_src = SRC_SEQ;
    if (ex_redirect)          next_src = SRC_EXC;
    else if (stall)           next_src = SRC_HOLD;
    else if (id_jr)           next_src = (id_jr_ra && !ras_empty) ? SRC_RAS : SRC_JR;
    else if (id_jump)         next_src = SRC_J;
    else if (id_branch_taken) next_src = SRC_BR;
  end

  always_comb begin
    raw_pc = pc_plus4_out;
    case (next_src)
      SRC_EXC:  raw_pc = ex_redirect_pc;
      SRC_HOLD: raw_pc = pc_out;
      SRC_RAS:  raw_pc = ras_top;
      SRC_JR:   raw_pc = id_jr_target;
      SRC_J:    raw_pc = {id_pc_plus4[ADDR_W-1:28], id_instr_index, 2'b00};
      SRC_BR:   raw_pc = id_pc_plus4 + (id_ext_imm << 2);
      default:  raw_pc = pc_plus4_out;
    endcase
  end

  // A RAS hit is exactly the pop condition; stall and redirect already excluded by next_src
  assign ras_hit  = (next_src == SRC_RAS);
  assign ras_push = id_push && (next_src != SRC_EXC) && (next_src != SRC_HOLD);

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_hit),
    .push_data (id_pc_plus4 + ADDR_W'(4)),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

`ifdef NPC_ALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (raw_pc[1:0] != 2'b00);
  assign next_pc    = misaligned ? TRAP_PC : raw_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out        <= RESET_PC;
      misalign_trap <= 1'b0;
    end else begin
      pc_out        <= next_pc;
      misalign_trap <= misaligned;
    end
  end
`else
  assign next_pc = raw_pc & ~ADDR_W'(3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_out <= RESET_PC;
    else     pc_out <= next_pc;
  end
`endif

endmodule

// File: tb/tb_npc_ras_unit.sv
// tb/tb_npc_ras_unit.sv - directed self-checking bench for npc_ras_unit
// Build with or without NPC_ALIGN_TRAP_EN; alignment expectations follow the macro.
module tb_npc_ras_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic [31:0] id_pc_plus4;
  logic        id_jr;
  logic        id_jr_ra;
  logic [31:0] id_jr_target;
  logic        id_jump;
  logic [25:0] id_instr_index;
  logic        id_branch_taken;
  logic [31:0] id_ext_imm;
  logic        id_push;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic        ras_hit;
  logic        ras_empty;
  logic        ras_full;
`ifdef NPC_ALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  npc_ras_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_redirect     (ex_redirect),
    .ex_redirect_pc  (ex_redirect_pc),
    .id_pc_plus4     (id_pc_plus4),
    .id_jr           (id_jr),
    .id_jr_ra        (id_jr_ra),
    .id_jr_target    (id_jr_target),
    .id_jump         (id_jump),
    .id_instr_index  (id_instr_index),
    .id_branch_taken (id_branch_taken),
    .id_ext_imm      (id_ext_imm),
    .id_push         (id_push),
    .pc_out          (pc_out),
    .pc_plus4_out    (pc_plus4_out),
    .ras_hit         (ras_hit),
    .ras_empty       (ras_empty),
`ifdef NPC_ALIGN_TRAP_EN
    .misalign_trap   (misalign_trap),
`endif
    .ras_full        (ras_full)
  );

  task automatic clear_inputs();
    stall = 0; ex_redirect = 0; ex_redirect_pc = '0; id_pc_plus4 = '0;
    id_jr = 0; id_jr_ra = 0; id_jr_target = '0; id_jump = 0;
    id_instr_index = '0; id_branch_taken = 0; id_ext_imm = '0; id_push = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    #1;
    @(negedge clk);
    rst = 0;
    #1;
    checks++; if (pc_out !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_out, 32'h3000); end
    checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_hit !== 1'b0) begin errors++; $display("FAIL reset_ras: empty=%b full=%b hit=%b want 1 0 0", ras_empty, ras_full, ras_hit); end
    checks++; if (pc_plus4_out !== 32'h3004) begin errors++; $display("FAIL reset_pc_plus4: got %h want %h", pc_plus4_out, 32'h3004); end
    step();
    checks++; if (pc_out !== 32'h3004) begin errors++; $display("FAIL seq1: got %h want %h", pc_out, 32'h3004); end
    step();
    checks++; if (pc_out !== 32'h3008) begin errors++; $display("FAIL seq2: got %h want %h", pc_out, 32'h3008); end
    #2 rst = 1;
    #1;
    checks++; if (pc_out !== 32'h3000) begin errors++; $display("FAIL async_reset: got %h want %h", pc_out, 32'h3000); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_branch_stall();
    clear_inputs();
    id_pc_plus4 = 32'h3010; id_branch_taken = 1; id_ext_imm = 32'hFFFF_FFFC;
    step();
    checks++; if (pc_out !== 32'h3000) begin errors++; $display("FAIL branch_back: got %h want %h", pc_out, 32'h3000); end
    id_ext_imm = 32'h1; stall = 1;
    #1;
    checks++; if (ras_hit !== 1'b0) begin errors++; $display("FAIL stall_hit: got %b want 0", ras_hit); end
    step();
    checks++; if (pc_out !== 32'h3000) begin errors++; $display("FAIL stall_hold: got %h want %h", pc_out, 32'h3000); end
    ex_redirect = 1; ex_redirect_pc = 32'h5000;
    step();
    checks++; if (pc_out !== 32'h5000) begin errors++; $display("FAIL redirect_over_stall: got %h want %h", pc_out, 32'h5000); end
    clear_inputs();
    id_pc_plus4 = 32'h5004; id_branch_taken = 1; id_ext_imm = 32'h10;
    step();
    checks++; if (pc_out !== 32'h5044) begin errors++; $display("FAIL branch_fwd: got %h want %h", pc_out, 32'h5044); end
  endtask

  task automatic test_jump();
    clear_inputs();
    id_jump = 1; id_pc_plus4 = 32'h3000_0014; id_instr_index = 26'h0000100;
    id_branch_taken = 1; id_ext_imm = 32'h40;
    step();
    checks++; if (pc_out !== 32'h3000_0400) begin errors++; $display("FAIL jump: got %h want %h", pc_out, 32'h3000_0400); end
    clear_inputs();
    step();
    checks++; if (pc_out !== 32'h3000_0404) begin errors++; $display("FAIL seq_after_jump: got %h want %h", pc_out, 32'h3000_0404); end
  endtask

  task automatic test_ras_basic();
    clear_inputs();
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ras_start_empty: got %b want 1", ras_empty); end
    id_jump = 1; id_push = 1; id_pc_plus4 = 32'h3104; id_instr_index = 26'h0000C80;
    step();
    checks++; if (pc_out !== 32'h0000_3200 || ras_empty !== 1'b0) begin errors++; $display("FAIL jal: pc=%h empty=%b want 00003200 0", pc_out, ras_empty); end
    clear_inputs();
    id_jr = 1; id_jr_ra = 1; id_jr_target = 32'hDEAD_0000;
    #1;
    checks++; if (ras_hit !== 1'b1) begin errors++; $display("FAIL ras_hit_set: got %b want 1", ras_hit); end
    step();
    checks++; if (pc_out !== 32'h3108 || ras_empty !== 1'b1) begin errors++; $display("FAIL ras_pop: pc=%h empty=%b want 00003108 1", pc_out, ras_empty); end
    #1;
    checks++; if (ras_hit !== 1'b0) begin errors++; $display("FAIL ras_hit_empty: got %b want 0", ras_hit); end
    step();
    checks++; if (pc_out !== 32'hDEAD_0000) begin errors++; $display("FAIL jr_fallback: got %h want %h", pc_out, 32'hDEAD_0000); end
  endtask

  task automatic test_ras_depth();
    logic [31:0] exp_pc;
    clear_inputs();
    for (int k = 1; k <= 5; k++) begin
      id_push = 1; id_pc_plus4 = 32'h1000 * k;
      step();
      if (k == 3) begin
        checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL ras_full_early: got %b want 0", ras_full); end
      end
      if (k >= 4) begin
        checks++; if (ras_full !== 1'b1) begin errors++; $display("FAIL ras_full_push%0d: got %b want 1", k, ras_full); end
      end
    end
    clear_inputs();
    id_jr = 1; id_jr_ra = 1; id_jr_target = 32'h7770;
    for (int k = 5; k >= 1; k--) begin
      exp_pc = (k >= 2) ? (32'h1000 * k + 32'h4) : 32'h7770;
      step();
      checks++; if (pc_out !== exp_pc) begin errors++; $display("FAIL ras_pop_order%0d: got %h want %h", k, pc_out, exp_pc); end
    end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ras_drained: got %b want 1", ras_empty); end
  endtask

  task automatic test_push_pop_same();
    clear_inputs();
    id_push = 1; id_pc_plus4 = 32'h8000;
    step();
    id_jr = 1; id_jr_ra = 1; id_jr_target = 32'h1110; id_pc_plus4 = 32'h9000;
    step();
    checks++; if (pc_out !== 32'h8004 || ras_empty !== 1'b0) begin errors++; $display("FAIL jalr_ra_ra: pc=%h empty=%b want 00008004 0", pc_out, ras_empty); end
    id_push = 0;
    step();
    checks++; if (pc_out !== 32'h9004 || ras_empty !== 1'b1) begin errors++; $display("FAIL replaced_top: pc=%h empty=%b want 00009004 1", pc_out, ras_empty); end
  endtask

  task automatic test_align();
    clear_inputs();
    id_jr = 1; id_jr_target = 32'h3002;
    step();
`ifdef NPC_ALIGN_TRAP_EN
    checks++; if (pc_out !== 32'h4180 || misalign_trap !== 1'b1) begin errors++; $display("FAIL align_trap: pc=%h trap=%b want 00004180 1", pc_out, misalign_trap); end
    clear_inputs();
    step();
    checks++; if (pc_out !== 32'h4184 || misalign_trap !== 1'b0) begin errors++; $display("FAIL align_trap_pulse: pc=%h trap=%b want 00004184 0", pc_out, misalign_trap); end
    ex_redirect = 1; ex_redirect_pc = 32'h5003;
    step();
    checks++; if (pc_out !== 32'h4180 || misalign_trap !== 1'b1) begin errors++; $display("FAIL align_redirect: pc=%h trap=%b want 00004180 1", pc_out, misalign_trap); end
`else
    checks++; if (pc_out !== 32'h3000) begin errors++; $display("FAIL align_mask: got %h want %h", pc_out, 32'h3000); end
    clear_inputs();
    ex_redirect = 1; ex_redirect_pc = 32'h5003;
    step();
    checks++; if (pc_out !== 32'h5000) begin errors++; $display("FAIL align_redirect: got %h want %h", pc_out, 32'h5000); end
`endif
  endtask

  initial begin
    test_reset();
    test_branch_stall();
    test_jump();
    test_ras_basic();
    test_ras_depth();
    test_push_pop_same();
    test_align();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
